// File: rtl/regfile_32x32.sv
`timescale 1ns/1ps
// mux32_1: one-bit 32:1 selector built as a five-level mux2 tree.
module mux32_1 (
    input  logic [31:0] dataIn,
    input  logic [4:0]  sel,
    output logic        dataOut
);

    logic [15:0] l1;
    logic [7:0]  l2;
    logic [3:0]  l3;
    logic [1:0]  l4;

    // Each level halves the candidates using one select bit, LSB first.
    always_comb begin
        l1 = '0;
        l2 = '0;
        l3 = '0;
        l4 = '0;
        for (int unsigned i = 0; i < 16; i++) l1[i] = sel[0] ? dataIn[2*i+1] : dataIn[2*i];
        for (int unsigned i = 0; i < 8; i++)  l2[i] = sel[1] ? l1[2*i+1] : l1[2*i];
        for (int unsigned i = 0; i < 4; i++)  l3[i] = sel[2] ? l2[2*i+1] : l2[2*i];
        for (int unsigned i = 0; i < 2; i++)  l4[i] = sel[3] ? l3[2*i+1] : l3[2*i];
        dataOut = sel[4] ? l4[1] : l4[0];
    end

endmodule

// regfile_32x32: 32 x WIDTH register file, one write port, two
// combinational read ports, one hardwired-zero entry.
module regfile_32x32 #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             regWrite,
    input  logic [4:0]       writeReg,
    input  logic [WIDTH-1:0] writeData,
    input  logic [4:0]       readReg1,
    input  logic [4:0]       readReg2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2
);

    logic [WIDTH-1:0] regs [32];
    logic [31:0]      wen;
    logic [31:0]      col  [WIDTH];

    // Write decoder: one-hot enable, never selects the zero register.
    always_comb begin
        wen = '0;
        if (regWrite && (writeReg != 5'(ZERO_REG)))
            wen[writeReg] = 1'b1;
    end

    // Register array with load enables; async reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < 32; r++) regs[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < 32; r++)
                if (wen[r]) regs[r] <= writeData;
        end
    end

    // Transpose into per-bit mux inputs; zero register inputs tied low.
    always_comb begin
        for (int unsigned b = 0; b < WIDTH; b++) begin
            col[b] = '0;
            for (int unsigned r = 0; r < 32; r++)
                col[b][r] = (r == ZERO_REG) ? 1'b0 : regs[r][b];
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mux32_1 u_rd1 (.dataIn(col[b]), .sel(readReg1), .dataOut(readData1[b]));
        mux32_1 u_rd2 (.dataIn(col[b]), .sel(readReg2), .dataOut(readData2[b]));
    end

endmodule
